wordline_sweep_decoder: RTL and testbench
=========================================

WORDLINE_SWEEP_DECODER -- requirements
Module: wordline_sweep_decoder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 3: address width; LINES = 2**ADDR_W (derived, not overridable).
REQ-002 The block SHALL have parameter SWEEP_HOLD, default 1: cycles each wordline is held during a sweep; legal range 1..255.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port en, input, 1 bit: normal-mode decode enable.
REQ-006 The block SHALL have port addr, input, ADDR_W bits: normal-mode line select.
REQ-007 The block SHALL have port sweep_start, input, 1 bit: request to walk all lines 0..LINES-1.
REQ-008 The block SHALL have port wordline, output, LINES bits: registered one-hot line select, or all-zero.
REQ-009 The block SHALL have port wl_idx, output, ADDR_W bits: binary index of the asserted wordline bit; 0 when none is asserted.
REQ-010 The block SHALL have port wl_valid, output, 1 bit: high exactly when wordline is non-zero.
REQ-011 The block SHALL have port sweep_busy, output, 1 bit: high in the SWEEP and DONE states.
REQ-012 The block SHALL have port sweep_done, output, 1 bit: single-cycle pulse marking sweep completion.

Function
REQ-013 wordline SHALL be either all-zero or exactly one-hot in every cycle; wl_idx and wl_valid SHALL be registered alongside wordline and consistent with it in the same cycle.
REQ-014 FSM states SHALL be IDLE, SWEEP and DONE.
REQ-015 In IDLE with en=1 and sweep_start=0 at edge t, from t+1 wordline SHALL equal one-hot(addr) and wl_idx SHALL equal addr (latency 1).
REQ-016 In IDLE with en=0 and sweep_start=0, wordline SHALL be all-zero from the next cycle.
REQ-017 In IDLE with sweep_start=1, the FSM SHALL enter SWEEP regardless of en; from the next cycle wordline SHALL equal one-hot(0), the line counter SHALL be 0 and the hold counter SHALL be 0.
REQ-018 In SWEEP, each line SHALL be held for exactly SWEEP_HOLD cycles, then the counter SHALL advance by 1; there SHALL be no gap cycles between lines.
REQ-019 After line LINES-1 has been held for SWEEP_HOLD cycles, the FSM SHALL enter DONE for exactly one cycle with wordline=0 and sweep_done=1, then return to IDLE.
REQ-020 The total sweep_busy high time SHALL be LINES*SWEEP_HOLD+1 cycles.
REQ-021 In SWEEP and DONE, en, addr and sweep_start SHALL be ignored; a sweep_start seen in DONE SHALL NOT start a new sweep.
REQ-022 The line counter SHALL be ADDR_W bits wide and SHALL NOT wrap past LINES-1; the hold counter SHALL be 8 bits wide.
REQ-023 sweep_done SHALL be high only in DONE.

Reset
REQ-024 With rst_n=0 at a rising edge, on the next cycle the FSM SHALL be in IDLE, both counters SHALL be 0, and wordline, wl_idx, wl_valid, sweep_busy and sweep_done SHALL all be 0.
REQ-025 A reset asserted mid-sweep SHALL abort the sweep without producing a sweep_done pulse.
REQ-026 The first rising edge with rst_n=1 SHALL be treated as a normal IDLE cycle.

Structure
REQ-027 A shared package SHALL hold the FSM state typedef (IDLE/SWEEP/DONE) and the hold-counter width constant (8).
REQ-028 The combinational binary-to-one-hot conversion SHALL be a parametrised sub-module, onehot_decoder (ADDR_W in, 2**ADDR_W out), instantiated once and driven by a mux of addr and the line counter.

Verification (ADDR_W=3, SWEEP_HOLD=2 unless stated)
REQ-029 Scenario 1: IDLE, en=1, addr=5 at edge t -> wordline=8'b0010_0000, wl_idx=5, wl_valid=1 at t+1; then en=0 -> wordline=0, wl_valid=0 at the next cycle.
REQ-030 Scenario 2: sweep_start pulse at edge t -> wordline holds 0x01 at t+1..t+2, 0x02 at t+3..t+4, ..., 0x80 at t+15..t+16; sweep_done=1 and wordline=0 at t+17; sweep_busy high for 17 cycles.
REQ-031 Scenario 3: en=1, addr=6 and sweep_start=1 in the same IDLE cycle -> sweep wins and wordline=0x01 next cycle; addr changes during the sweep have no effect.
REQ-032 Scenario 4: rst_n=0 for one edge while line 3 is active mid-sweep -> all outputs are 0 next cycle, no sweep_done pulse, and a following en=1, addr=2 gives wordline=0x04.
REQ-033 Scenario 5: sweep_start held high continuously -> back-to-back sweeps separated by exactly one IDLE cycle, with exactly one sweep_done pulse per sweep.
REQ-034 Scenario 6: ADDR_W=4, SWEEP_HOLD=1 -> 16 consecutive one-hot lines, sweep_done at cycle t+17, and a one-hot/zero invariant check that passes every cycle.

Source files
------------

// File: rtl/wordline_sweep_decoder_pkg.sv
// Shared types and constants for the wordline sweep decoder.
package wordline_sweep_decoder_pkg;

  // Width of the per-line hold counter; supports hold times up to 255 cycles.
  localparam int unsigned HOLD_W = 8;

  // FSM state encoding.
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SWEEP = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

endpackage : wordline_sweep_decoder_pkg

// File: rtl/wordline_sweep_decoder_onehot.sv
// Parametrised combinational binary-to-one-hot decoder.
module onehot_decoder #(
  parameter int unsigned ADDR_W = 3
) (
  input  logic [ADDR_W-1:0]      idx,
  output logic [(2**ADDR_W)-1:0] onehot_c
);

  // Set exactly the bit selected by idx.
  always_comb begin
    onehot_c      = '0;
    onehot_c[idx] = 1'b1;
  end

endmodule : onehot_decoder

// File: rtl/wordline_sweep_decoder.sv
// Wordline decoder with a normal addressed mode and a timed sweep of all lines.
module wordline_sweep_decoder
  import wordline_sweep_decoder_pkg::*;
#(
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned SWEEP_HOLD = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [ADDR_W-1:0]         addr,
  input  logic                      sweep_start,
  output logic [(2**ADDR_W)-1:0]    wordline,
  output logic [ADDR_W-1:0]         wl_idx,
  output logic                      wl_valid,
  output logic                      sweep_busy,
  output logic                      sweep_done
);

  localparam int unsigned       LINES     = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(LINES - 1);
  localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(SWEEP_HOLD - 1);

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   line_q;
  logic [ADDR_W-1:0]   line_d;
  logic [HOLD_W-1:0]   hold_q;
  logic [HOLD_W-1:0]   hold_d;

  // Decoder feed: either addr (normal mode) or the upcoming sweep line.
  logic [ADDR_W-1:0]   sel_idx_c;
  logic                sel_en_c;
  logic                done_d;
  logic [LINES-1:0]    onehot_c;

  // Single shared decoder; its output is gated and registered below.
  onehot_decoder #(
    .ADDR_W (ADDR_W)
  ) u_onehot_decoder (
    .idx      (sel_idx_c),
    .onehot_c (onehot_c)
  );

  // Next-state, counter and decoder-select logic.
  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    hold_d    = hold_q;
    sel_idx_c = addr;
    sel_en_c  = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sweep_start) begin
          // Sweep takes priority over a normal decode in the same cycle.
          state_d   = ST_SWEEP;
          line_d    = '0;
          hold_d    = '0;
          sel_idx_c = '0;
          sel_en_c  = 1'b1;
        end else begin
          sel_idx_c = addr;
          sel_en_c  = en;
        end
      end

      ST_SWEEP: begin
        if (hold_q == LAST_HOLD) begin
          if (line_q == LAST_LINE) begin
            // Last line finished: one blank DONE cycle, counter stays put.
            state_d  = ST_DONE;
            hold_d   = '0;
            done_d   = 1'b1;
            sel_en_c = 1'b0;
          end else begin
            line_d    = line_q + ADDR_W'(1);
            hold_d    = '0;
            sel_idx_c = line_q + ADDR_W'(1);
            sel_en_c  = 1'b1;
          end
        end else begin
          hold_d    = hold_q + HOLD_W'(1);
          sel_idx_c = line_q;
          sel_en_c  = 1'b1;
        end
      end

      ST_DONE: begin
        // All inputs ignored here, including a fresh sweep_start.
        state_d = ST_IDLE;
        line_d  = '0;
        hold_d  = '0;
      end

      default: begin
        state_d = ST_IDLE;
        line_d  = '0;
        hold_d  = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      line_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      hold_q  <= hold_d;
    end
  end

  // Registered outputs, all updated together so they stay mutually consistent.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wordline   <= '0;
      wl_idx     <= '0;
      wl_valid   <= 1'b0;
      sweep_busy <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      wordline   <= sel_en_c ? onehot_c : '0;
      wl_idx     <= sel_en_c ? sel_idx_c : '0;
      wl_valid   <= sel_en_c;
      sweep_busy <= (state_d == ST_SWEEP) || (state_d == ST_DONE);
      sweep_done <= done_d;
    end
  end

endmodule : wordline_sweep_decoder

// File: tb/tb_wordline_sweep_decoder.sv
// Directed self-checking bench for wordline_sweep_decoder.
module tb_wordline_sweep_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [2:0]  addr;
  logic        sweep_start;
  logic [7:0]  wordline;
  logic [2:0]  wl_idx;
  logic        wl_valid;
  logic        sweep_busy;
  logic        sweep_done;

  logic        en_w;
  logic [3:0]  addr_w;
  logic        start_w;
  logic [15:0] wordline_w;
  logic [3:0]  idx_w;
  logic        valid_w;
  logic        busy_w;
  logic        done_w;

  int n_cmp = 0;
  int n_bad = 0;
  bit inv_on = 1'b0;

  always #5 clk = ~clk;

  wordline_sweep_decoder #(.ADDR_W(3), .SWEEP_HOLD(2)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .addr        (addr),
    .sweep_start (sweep_start),
    .wordline    (wordline),
    .wl_idx      (wl_idx),
    .wl_valid    (wl_valid),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done)
  );

  wordline_sweep_decoder #(.ADDR_W(4), .SWEEP_HOLD(1)) u_dut_w (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en_w),
    .addr        (addr_w),
    .sweep_start (start_w),
    .wordline    (wordline_w),
    .wl_idx      (idx_w),
    .wl_valid    (valid_w),
    .sweep_busy  (busy_w),
    .sweep_done  (done_w)
  );

  // Every-cycle invariant: zero-or-one-hot, and idx/valid agree with wordline.
  always @(negedge clk) begin
    if (inv_on) begin
      n_cmp++;
      if (!$onehot0(wordline) || (wl_valid !== (wordline != 8'h00)) ||
          (wl_valid && (wordline !== (8'(1) << wl_idx))) ||
          (!wl_valid && (wl_idx !== 3'd0)) || (sweep_done && !sweep_busy)) begin
        n_bad++;
        $display("FAIL invariant8: wl=%h idx=%0d valid=%b busy=%b done=%b", wordline, wl_idx, wl_valid, sweep_busy, sweep_done);
      end
      n_cmp++;
      if (!$onehot0(wordline_w) || (valid_w !== (wordline_w != 16'h0000)) ||
          (valid_w && (wordline_w !== (16'(1) << idx_w))) ||
          (!valid_w && (idx_w !== 4'd0)) || (done_w && !busy_w)) begin
        n_bad++;
        $display("FAIL invariant16: wl=%h idx=%0d valid=%b busy=%b done=%b", wordline_w, idx_w, valid_w, busy_w, done_w);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; addr = 3'd0; sweep_start = 1'b0;
    en_w = 1'b0; addr_w = 4'd0; start_w = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({wordline, wl_idx, wl_valid, sweep_busy, sweep_done} !== 14'd0) begin
      n_bad++;
      $display("FAIL reset8: got wl=%h idx=%0d v=%b busy=%b done=%b, want all 0", wordline, wl_idx, wl_valid, sweep_busy, sweep_done);
    end
    n_cmp++;
    if ({wordline_w, idx_w, valid_w, busy_w, done_w} !== 23'd0) begin
      n_bad++;
      $display("FAIL reset16: got wl=%h idx=%0d v=%b busy=%b done=%b, want all 0", wordline_w, idx_w, valid_w, busy_w, done_w);
    end
    rst_n  = 1'b1;
    inv_on = 1'b1;
    tick();
  endtask

  task automatic test_normal();
    logic [2:0]  a_tab  [3] = '{3'd5, 3'd0, 3'd7};
    logic [7:0]  wl_tab [3] = '{8'b0010_0000, 8'b0000_0001, 8'b1000_0000};
    for (int i = 0; i < 3; i++) begin
      en = 1'b1; addr = a_tab[i];
      tick();
      n_cmp++;
      if ({wordline, wl_idx, wl_valid, sweep_busy, sweep_done} !== {wl_tab[i], a_tab[i], 1'b1, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL normal addr=%0d: got wl=%h idx=%0d v=%b busy=%b, want wl=%h idx=%0d v=1 busy=0", a_tab[i], wordline, wl_idx, wl_valid, sweep_busy, wl_tab[i], a_tab[i]);
      end
    end
    en = 1'b0;
    tick();
    n_cmp++;
    if ({wordline, wl_idx, wl_valid} !== 12'd0) begin
      n_bad++;
      $display("FAIL normal_disable: got wl=%h idx=%0d v=%b, want 0 0 0", wordline, wl_idx, wl_valid);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] exp_wl;
    logic [2:0] k;
    int busy_cnt = 0;
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      k = 3'((c - 1) / 2);
      exp_wl = 8'(1) << k;
      n_cmp++;
      if ({wordline, wl_idx, wl_valid, sweep_busy, sweep_done} !== {exp_wl, k, 1'b1, 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL sweep t+%0d: got wl=%h idx=%0d busy=%b done=%b, want wl=%h idx=%0d busy=1 done=0", c, wordline, wl_idx, sweep_busy, sweep_done, exp_wl, k);
      end
      if (sweep_busy) busy_cnt++;
      tick();
    end
    n_cmp++;
    if ({wordline, wl_idx, wl_valid, sweep_busy, sweep_done} !== {8'h00, 3'd0, 1'b0, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL sweep_done_cycle: got wl=%h busy=%b done=%b, want wl=00 busy=1 done=1", wordline, sweep_busy, sweep_done);
    end
    if (sweep_busy) busy_cnt++;
    tick();
    n_cmp++;
    if ({wordline, sweep_busy, sweep_done} !== 10'd0) begin
      n_bad++;
      $display("FAIL sweep_after: got wl=%h busy=%b done=%b, want all 0", wordline, sweep_busy, sweep_done);
    end
    n_cmp++;
    if (busy_cnt != 17) begin
      n_bad++;
      $display("FAIL sweep_busy_len: got %0d cycles, want 17", busy_cnt);
    end
  endtask

  task automatic test_sweep_priority();
    logic [7:0] exp_wl;
    logic [2:0] k;
    en = 1'b1; addr = 3'd6; sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      k = 3'((c - 1) / 2);
      exp_wl = 8'(1) << k;
      n_cmp++;
      if ({wordline, wl_idx, sweep_busy, sweep_done} !== {exp_wl, k, 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL priority t+%0d: got wl=%h idx=%0d busy=%b done=%b, want wl=%h idx=%0d busy=1 done=0", c, wordline, wl_idx, sweep_busy, sweep_done, exp_wl, k);
      end
      en = 1'b1;
      addr = 3'($urandom_range(0, 7));
      sweep_start = (c == 5);
      tick();
    end
    n_cmp++;
    if ({wordline, sweep_busy, sweep_done} !== {8'h00, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL priority_done: got wl=%h busy=%b done=%b, want wl=00 busy=1 done=1", wordline, sweep_busy, sweep_done);
    end
    // Requests presented during DONE must be dropped.
    sweep_start = 1'b1; en = 1'b1; addr = 3'd6;
    tick();
    n_cmp++;
    if ({wordline, wl_valid, sweep_busy, sweep_done} !== 11'd0) begin
      n_bad++;
      $display("FAIL done_ignores_start: got wl=%h v=%b busy=%b done=%b, want all 0", wordline, wl_valid, sweep_busy, sweep_done);
    end
    sweep_start = 1'b0; en = 1'b0;
    tick();
    n_cmp++;
    if ({wordline, sweep_busy} !== 9'd0) begin
      n_bad++;
      $display("FAIL priority_idle: got wl=%h busy=%b, want 0 0", wordline, sweep_busy);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int done_seen = 0;
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    n_cmp++;
    if ({wordline, wl_idx, sweep_busy} !== {8'h08, 3'd3, 1'b1}) begin
      n_bad++;
      $display("FAIL pre_reset_line3: got wl=%h idx=%0d busy=%b, want wl=08 idx=3 busy=1", wordline, wl_idx, sweep_busy);
    end
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if ({wordline, wl_idx, wl_valid, sweep_busy, sweep_done} !== 14'd0) begin
      n_bad++;
      $display("FAIL mid_reset: got wl=%h idx=%0d v=%b busy=%b done=%b, want all 0", wordline, wl_idx, wl_valid, sweep_busy, sweep_done);
    end
    rst_n = 1'b1; en = 1'b1; addr = 3'd2;
    tick();
    n_cmp++;
    if ({wordline, wl_idx, wl_valid, sweep_busy, sweep_done} !== {8'h04, 3'd2, 1'b1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL post_reset_decode: got wl=%h idx=%0d v=%b busy=%b done=%b, want wl=04 idx=2 v=1 busy=0 done=0", wordline, wl_idx, wl_valid, sweep_busy, sweep_done);
    end
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sweep_done) done_seen++;
      tick();
    end
    n_cmp++;
    if (done_seen != 0) begin
      n_bad++;
      $display("FAIL aborted_no_done: got %0d done pulses, want 0", done_seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_wl;
    logic [2:0] k;
    logic       exp_busy;
    logic       exp_done;
    int         p;
    int         done_cnt = 0;
    sweep_start = 1'b1;
    tick();
    for (int c = 1; c <= 54; c++) begin
      p = (c - 1) % 18;
      if (p < 16) begin
        k = 3'(p / 2); exp_wl = 8'(1) << k; exp_busy = 1'b1; exp_done = 1'b0;
      end else begin
        k = 3'd0; exp_wl = 8'h00; exp_busy = (p == 16); exp_done = (p == 16);
      end
      n_cmp++;
      if ({wordline, wl_idx, sweep_busy, sweep_done} !== {exp_wl, k, exp_busy, exp_done}) begin
        n_bad++;
        $display("FAIL b2b c=%0d: got wl=%h idx=%0d busy=%b done=%b, want wl=%h idx=%0d busy=%b done=%b", c, wordline, wl_idx, sweep_busy, sweep_done, exp_wl, k, exp_busy, exp_done);
      end
      if (sweep_done) done_cnt++;
      if (c == 54) sweep_start = 1'b0;
      tick();
    end
    n_cmp++;
    if (done_cnt != 3) begin
      n_bad++;
      $display("FAIL b2b_done_count: got %0d, want 3", done_cnt);
    end
    n_cmp++;
    if ({wordline, sweep_busy} !== 9'd0) begin
      n_bad++;
      $display("FAIL b2b_stop: got wl=%h busy=%b, want 0 0", wordline, sweep_busy);
    end
  endtask

  task automatic test_wide();
    logic [15:0] exp_wl;
    logic [3:0]  k;
    en_w = 1'b1; addr_w = 4'hB;
    tick();
    n_cmp++;
    if ({wordline_w, idx_w, valid_w} !== {16'h0800, 4'hB, 1'b1}) begin
      n_bad++;
      $display("FAIL wide_decode: got wl=%h idx=%0d v=%b, want wl=0800 idx=11 v=1", wordline_w, idx_w, valid_w);
    end
    en_w = 1'b0; start_w = 1'b1;
    tick();
    start_w = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      k = 4'(c - 1);
      exp_wl = 16'(1) << k;
      n_cmp++;
      if ({wordline_w, idx_w, busy_w, done_w} !== {exp_wl, k, 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL wide_sweep t+%0d: got wl=%h idx=%0d busy=%b done=%b, want wl=%h idx=%0d busy=1 done=0", c, wordline_w, idx_w, busy_w, done_w, exp_wl, k);
      end
      tick();
    end
    n_cmp++;
    if ({wordline_w, busy_w, done_w} !== {16'h0000, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL wide_done t+17: got wl=%h busy=%b done=%b, want wl=0000 busy=1 done=1", wordline_w, busy_w, done_w);
    end
    tick();
    n_cmp++;
    if ({wordline_w, busy_w, done_w} !== 18'd0) begin
      n_bad++;
      $display("FAIL wide_after: got wl=%h busy=%b done=%b, want all 0", wordline_w, busy_w, done_w);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_sweep();
    test_sweep_priority();
    test_reset_mid_sweep();
    test_back_to_back();
    test_wide();
    tick();
    inv_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule : tb_wordline_sweep_decoder
